// File: rtl/ins_pkg.sv
// Shared types for the instruction dispatcher:
// opcodes, bank states and the instruction word layout.
package ins_pkg;

  localparam int INS_W   = 64;
  localparam int OPC_MSB = 63;
  localparam int OPC_LSB = 60;
  localparam int BNK_MSB = 59;
  localparam int BNK_LSB = 56;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_CONF = 4'd1,
    OP_LOAD = 4'd2,
    OP_CALC = 4'd3,
    OP_SAVE = 4'd4
  } opcode_e;

  typedef enum logic [2:0] {
    BS_FREE,
    BS_LOADING,
    BS_LOADED,
    BS_CALCING,
    BS_CALCED,
    BS_SAVING
  } bank_state_t;

  typedef struct packed {
    logic [OPC_MSB-OPC_LSB:0] opc;
    logic [BNK_MSB-BNK_LSB:0] bank;
    logic [BNK_LSB-1:0]       payload;
  } ins_t;

  function automatic logic bank_quiet(bank_state_t s);
    return (s == BS_FREE) || (s == BS_LOADED);
  endfunction

endpackage

// File: rtl/ins_fifo.sv
// First-word-fall-through synchronous FIFO with
// occupancy count; head word is visible on o_data.
module ins_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_cnt;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_data  = r_mem[r_rp];

  // a full FIFO still accepts a word when the head leaves in the same cycle
  assign w_rd = i_pop && !o_empty;
  assign w_wr = i_push && (!o_full || w_rd);

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= i_data;
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + AW'(1);
      if (w_rd) r_rp <= r_rp + AW'(1);
      unique case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/ins_dispatcher.sv
// In-order instruction issue with a per-bank
// LOAD->CALC->SAVE scoreboard.
module ins_dispatcher
  import ins_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int BANK_NUM   = 2,
  parameter int LD_CNT_W   = 3
) (
  input  logic                        core_clk,
  input  logic                        core_rst_n,
  input  logic                        ins_valid,
  output logic                        ins_ready,
  input  logic [INS_W-1:0]            ins,
  output logic                        conf_valid,
  input  logic                        conf_ready,
  output logic                        ld_valid,
  input  logic                        ld_ready,
  output logic                        calc_valid,
  input  logic                        calc_ready,
  output logic                        sv_valid,
  input  logic                        sv_ready,
  output logic [INS_W-1:0]            issue_ins,
  input  logic                        ld_done,
  input  logic                        calc_done,
  input  logic                        sv_done,
  input  logic [$clog2(BANK_NUM)-1:0] ld_done_bank,
  input  logic [$clog2(BANK_NUM)-1:0] calc_done_bank,
  input  logic [$clog2(BANK_NUM)-1:0] sv_done_bank,
  output logic                        working,
  output logic                        err_illegal,
  output logic                        err_seq
);

  localparam int BW = $clog2(BANK_NUM);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic             w_push;
  logic             w_pop;
  logic [INS_W-1:0] w_head;
  logic [CW-1:0]    w_count;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_full;
  logic             w_empty;
  ins_t             w_hd;

  bank_state_t         r_st    [BANK_NUM];
  logic [LD_CNT_W-1:0] r_cnt   [BANK_NUM];
  bank_state_t         w_st_c  [BANK_NUM];
  logic [LD_CNT_W-1:0] w_cnt_c [BANK_NUM];
  bank_state_t         w_st_n  [BANK_NUM];
  logic [LD_CNT_W-1:0] w_cnt_n [BANK_NUM];

  logic             r_conf_v, r_ld_v, r_calc_v, r_sv_v;
  logic             w_conf_v, w_ld_v, w_calc_v, w_sv_v;
  logic [INS_W-1:0] r_issue;
  logic             r_err_ill, r_err_seq, r_working;

  logic        w_seq;
  logic        w_ill;
  logic        w_any_v;
  logic        w_busy;
  logic        w_all_quiet;
  logic        w_bok;
  bank_state_t w_bst;
  logic [LD_CNT_W-1:0] w_bcnt;
  logic        w_is_conf, w_is_ld, w_is_calc, w_is_sv;
  logic        w_work_n;

  assign ins_ready = !w_full;
  assign w_push    = ins_valid && ins_ready;
  assign w_hd      = ins_t'(w_head);

  ins_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INS_W)
  ) u_fifo (
    .clk     (core_clk),
    .rst_n   (core_rst_n),
    .i_push  (w_push),
    .i_data  (ins),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_any_v = r_conf_v | r_ld_v | r_calc_v | r_sv_v;
  assign w_busy  = (r_conf_v && !conf_ready) || (r_ld_v && !ld_ready)
                || (r_calc_v && !calc_ready) || (r_sv_v && !sv_ready);
  assign w_bok   = 32'(w_hd.bank) < BANK_NUM;

  // apply this cycle's completion pulses before the hazard check
  always_comb begin
    w_st_c  = r_st;
    w_cnt_c = r_cnt;
    w_seq   = 1'b0;
    for (int b = 0; b < BANK_NUM; b++) begin
      if (ld_done && ld_done_bank == BW'(b)) begin
        if (r_cnt[b] == '0) begin
          w_seq = 1'b1;
        end else begin
          w_cnt_c[b] = r_cnt[b] - LD_CNT_W'(1);
          if (r_cnt[b] == LD_CNT_W'(1)) w_st_c[b] = BS_LOADED;
        end
      end
      if (calc_done && calc_done_bank == BW'(b)) begin
        if (r_st[b] == BS_CALCING) w_st_c[b] = BS_CALCED;
        else                       w_seq = 1'b1;
      end
      if (sv_done && sv_done_bank == BW'(b)) begin
        if (r_st[b] == BS_SAVING) w_st_c[b] = BS_FREE;
        else                      w_seq = 1'b1;
      end
    end
  end

  // post-completion view of the head's bank and of all banks
  always_comb begin
    w_bst       = BS_FREE;
    w_bcnt      = '0;
    w_all_quiet = 1'b1;
    for (int b = 0; b < BANK_NUM; b++) begin
      if (w_hd.bank == 4'(b)) begin
        w_bst  = w_st_c[b];
        w_bcnt = w_cnt_c[b];
      end
      if (!bank_quiet(w_st_c[b]) || w_cnt_c[b] != '0) w_all_quiet = 1'b0;
    end
  end

  // head decode and hazard check
  always_comb begin
    w_pop     = 1'b0;
    w_ill     = 1'b0;
    w_is_conf = 1'b0;
    w_is_ld   = 1'b0;
    w_is_calc = 1'b0;
    w_is_sv   = 1'b0;
    if (!w_empty && !w_busy) begin
      unique case (1'b1)
        (w_hd.opc == OP_NOP): w_pop = 1'b1;
        (w_hd.opc == OP_CONF): begin
          w_is_conf = w_all_quiet && !w_any_v;
          w_pop     = w_is_conf;
        end
        (w_hd.opc == OP_LOAD && w_bok): begin
          w_is_ld = (w_bst == BS_FREE || w_bst == BS_LOADING
                  || w_bst == BS_LOADED) && (w_bcnt != '1);
          w_pop   = w_is_ld;
        end
        (w_hd.opc == OP_CALC && w_bok): begin
          w_is_calc = (w_bst == BS_LOADED);
          w_pop     = w_is_calc;
        end
        (w_hd.opc == OP_SAVE && w_bok): begin
          w_is_sv = (w_bst == BS_CALCED);
          w_pop   = w_is_sv;
        end
        default: begin
          w_pop = 1'b1;
          w_ill = 1'b1;
        end
      endcase
    end
  end

  // scoreboard update from the issued instruction and next flags
  always_comb begin
    w_st_n  = w_st_c;
    w_cnt_n = w_cnt_c;
    for (int b = 0; b < BANK_NUM; b++) begin
      if (w_hd.bank == 4'(b)) begin
        if (w_is_ld) begin
          w_st_n[b]  = BS_LOADING;
          w_cnt_n[b] = w_cnt_c[b] + LD_CNT_W'(1);
        end
        if (w_is_calc) w_st_n[b] = BS_CALCING;
        if (w_is_sv)   w_st_n[b] = BS_SAVING;
      end
    end
    w_conf_v  = w_is_conf || (r_conf_v && !conf_ready);
    w_ld_v    = w_is_ld   || (r_ld_v   && !ld_ready);
    w_calc_v  = w_is_calc || (r_calc_v && !calc_ready);
    w_sv_v    = w_is_sv   || (r_sv_v   && !sv_ready);
    w_cnt_nxt = w_count + CW'(w_push) - CW'(w_pop);
    w_work_n  = (w_cnt_nxt != '0) || w_conf_v || w_ld_v
             || w_calc_v || w_sv_v;
    for (int b = 0; b < BANK_NUM; b++) begin
      if (!bank_quiet(w_st_n[b])) w_work_n = 1'b1;
    end
  end

  // state, issue and flag registers
  always_ff @(posedge core_clk) begin
    if (!core_rst_n) begin
      for (int b = 0; b < BANK_NUM; b++) begin
        r_st[b]  <= BS_FREE;
        r_cnt[b] <= '0;
      end
      r_conf_v  <= 1'b0;
      r_ld_v    <= 1'b0;
      r_calc_v  <= 1'b0;
      r_sv_v    <= 1'b0;
      r_issue   <= '0;
      r_err_ill <= 1'b0;
      r_err_seq <= 1'b0;
      r_working <= 1'b0;
    end else begin
      r_st      <= w_st_n;
      r_cnt     <= w_cnt_n;
      r_conf_v  <= w_conf_v;
      r_ld_v    <= w_ld_v;
      r_calc_v  <= w_calc_v;
      r_sv_v    <= w_sv_v;
      if (w_is_conf || w_is_ld || w_is_calc || w_is_sv) r_issue <= w_head;
      r_err_ill <= w_ill;
      r_err_seq <= w_seq;
      r_working <= w_work_n;
    end
  end

  assign conf_valid  = r_conf_v;
  assign ld_valid    = r_ld_v;
  assign calc_valid  = r_calc_v;
  assign sv_valid    = r_sv_v;
  assign issue_ins   = r_issue;
  assign err_illegal = r_err_ill;
  assign err_seq     = r_err_seq;
  assign working     = r_working;

endmodule

// File: tb/tb_ins_dispatcher.sv
// Directed bench for ins_dispatcher: per-cycle vector
// table plus hand sequences for multi-cycle cases.
module tb_ins_dispatcher;
  import ins_pkg::*;

  logic        core_clk = 1'b0;
  logic        core_rst_n;
  logic        ins_valid;
  logic        ins_ready;
  logic [63:0] ins;
  logic        conf_valid, conf_ready;
  logic        ld_valid, ld_ready;
  logic        calc_valid, calc_ready;
  logic        sv_valid, sv_ready;
  logic [63:0] issue_ins;
  logic        ld_done, calc_done, sv_done;
  logic        ld_done_bank, calc_done_bank, sv_done_bank;
  logic        working, err_illegal, err_seq;

  int n_chk = 0;
  int n_err = 0;

  always #5 core_clk = ~core_clk;

  ins_dispatcher #(
    .FIFO_DEPTH (8),
    .BANK_NUM   (2),
    .LD_CNT_W   (3)
  ) dut (
    .core_clk       (core_clk),
    .core_rst_n     (core_rst_n),
    .ins_valid      (ins_valid),
    .ins_ready      (ins_ready),
    .ins            (ins),
    .conf_valid     (conf_valid),
    .conf_ready     (conf_ready),
    .ld_valid       (ld_valid),
    .ld_ready       (ld_ready),
    .calc_valid     (calc_valid),
    .calc_ready     (calc_ready),
    .sv_valid       (sv_valid),
    .sv_ready       (sv_ready),
    .issue_ins      (issue_ins),
    .ld_done        (ld_done),
    .calc_done      (calc_done),
    .sv_done        (sv_done),
    .ld_done_bank   (ld_done_bank),
    .calc_done_bank (calc_done_bank),
    .sv_done_bank   (sv_done_bank),
    .working        (working),
    .err_illegal    (err_illegal),
    .err_seq        (err_seq)
  );

  typedef struct {
    logic        rst;
    logic        iv;
    logic [63:0] w;
    logic [2:0]  dn;
    logic [2:0]  db;
    logic [3:0]  ev;
    logic        ew;
    logic        eil;
    logic        esq;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic rst, logic iv, logic [63:0] w,
                             logic [2:0] dn, logic [2:0] db,
                             logic [3:0] ev, logic ew,
                             logic eil, logic esq);
    vec_t t;
    t.rst = rst; t.iv = iv; t.w = w; t.dn = dn; t.db = db;
    t.ev = ev; t.ew = ew; t.eil = eil; t.esq = esq;
    return t;
  endfunction

  function automatic logic [63:0] mk(logic [3:0] op, logic [3:0] b,
                                     logic [55:0] p);
    return {op, b, p};
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge core_clk);
    #1;
  endtask

  task automatic idle_in();
    ins_valid = 1'b0; ins = '0;
    ld_done = 1'b0; calc_done = 1'b0; sv_done = 1'b0;
    ld_done_bank = 1'b0; calc_done_bank = 1'b0; sv_done_bank = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    conf_ready = 1'b1; ld_ready = 1'b1;
    calc_ready = 1'b1; sv_ready = 1'b1;
    core_rst_n = 1'b0;
    step();
    core_rst_n = 1'b1;
  endtask

  task automatic push(logic [63:0] w);
    ins_valid = 1'b1; ins = w;
    step();
    ins_valid = 1'b0;
  endtask

  logic [63:0] L0, L1, L3, C0, C1, S0, CF, BAD;
  logic [3:0]  vv;
  int          got;

  initial begin
    L0  = mk(4'd2, 4'd0, 56'h00A0);
    L1  = mk(4'd2, 4'd1, 56'h00A1);
    L3  = mk(4'd2, 4'd3, 56'h00A3);
    C0  = mk(4'd3, 4'd0, 56'h00C0);
    C1  = mk(4'd3, 4'd1, 56'h00C1);
    S0  = mk(4'd4, 4'd0, 56'h0050);
    CF  = mk(4'd1, 4'd0, 56'h00CF);
    BAD = mk(4'hF, 4'd0, 56'h0BAD);

    idle_in();
    conf_ready = 1'b1; ld_ready = 1'b1;
    calc_ready = 1'b1; sv_ready = 1'b1;
    core_rst_n = 1'b0;

    // LOAD -> CALC -> SAVE on bank 0
    tbl.push_back(v(1,0,0, 3'b000,0, 4'b0000,0,0,0));
    tbl.push_back(v(0,1,L0,3'b000,0, 4'b0000,1,0,0));
    tbl.push_back(v(0,1,C0,3'b000,0, 4'b0100,1,0,0));
    tbl.push_back(v(0,1,S0,3'b000,0, 4'b0000,1,0,0));
    tbl.push_back(v(0,0,0, 3'b000,0, 4'b0000,1,0,0));
    tbl.push_back(v(0,0,0, 3'b100,0, 4'b0010,1,0,0));
    tbl.push_back(v(0,0,0, 3'b000,0, 4'b0000,1,0,0));
    tbl.push_back(v(0,0,0, 3'b010,0, 4'b0001,1,0,0));
    tbl.push_back(v(0,0,0, 3'b000,0, 4'b0000,1,0,0));
    tbl.push_back(v(0,0,0, 3'b001,0, 4'b0000,0,0,0));
    // two loads: CALC waits for both completions
    tbl.push_back(v(1,0,0, 3'b000,0, 4'b0000,0,0,0));
    tbl.push_back(v(0,1,L0,3'b000,0, 4'b0000,1,0,0));
    tbl.push_back(v(0,1,L0,3'b000,0, 4'b0100,1,0,0));
    tbl.push_back(v(0,1,C0,3'b000,0, 4'b0100,1,0,0));
    tbl.push_back(v(0,0,0, 3'b000,0, 4'b0000,1,0,0));
    tbl.push_back(v(0,0,0, 3'b100,0, 4'b0000,1,0,0));
    tbl.push_back(v(0,0,0, 3'b000,0, 4'b0000,1,0,0));
    tbl.push_back(v(0,0,0, 3'b100,0, 4'b0010,1,0,0));
    tbl.push_back(v(0,0,0, 3'b000,0, 4'b0000,1,0,0));
    // LOAD issue and ld_done on the same bank in one cycle
    tbl.push_back(v(1,0,0, 3'b000,0, 4'b0000,0,0,0));
    tbl.push_back(v(0,1,L0,3'b000,0, 4'b0000,1,0,0));
    tbl.push_back(v(0,0,0, 3'b000,0, 4'b0100,1,0,0));
    tbl.push_back(v(0,1,L0,3'b000,0, 4'b0000,1,0,0));
    tbl.push_back(v(0,0,0, 3'b100,0, 4'b0100,1,0,0));
    tbl.push_back(v(0,1,C0,3'b000,0, 4'b0000,1,0,0));
    tbl.push_back(v(0,0,0, 3'b000,0, 4'b0000,1,0,0));
    tbl.push_back(v(0,0,0, 3'b100,0, 4'b0010,1,0,0));
    tbl.push_back(v(0,0,0, 3'b000,0, 4'b0000,1,0,0));
    // back-to-back loads: one issue per cycle
    tbl.push_back(v(1,0,0, 3'b000,0, 4'b0000,0,0,0));
    tbl.push_back(v(0,1,L0,3'b000,0, 4'b0000,1,0,0));
    tbl.push_back(v(0,1,L1,3'b000,0, 4'b0100,1,0,0));
    tbl.push_back(v(0,1,L0,3'b000,0, 4'b0100,1,0,0));
    tbl.push_back(v(0,1,L1,3'b000,0, 4'b0100,1,0,0));
    tbl.push_back(v(0,0,0, 3'b000,0, 4'b0100,1,0,0));
    tbl.push_back(v(0,0,0, 3'b000,0, 4'b0000,1,0,0));
    // illegal opcode, bank out of range, stray sv_done
    tbl.push_back(v(1,0,0,  3'b000,0, 4'b0000,0,0,0));
    tbl.push_back(v(0,1,BAD,3'b000,0, 4'b0000,1,0,0));
    tbl.push_back(v(0,1,L3, 3'b000,0, 4'b0000,1,1,0));
    tbl.push_back(v(0,0,0,  3'b000,0, 4'b0000,0,1,0));
    tbl.push_back(v(0,0,0,  3'b001,0, 4'b0000,0,0,1));
    tbl.push_back(v(0,0,0,  3'b000,0, 4'b0000,0,0,0));
    // CONF with every bank quiet
    tbl.push_back(v(0,1,CF, 3'b000,0, 4'b0000,1,0,0));
    tbl.push_back(v(0,0,0,  3'b000,0, 4'b1000,1,0,0));
    tbl.push_back(v(0,0,0,  3'b000,0, 4'b0000,0,0,0));

    foreach (tbl[i]) begin
      core_rst_n = !tbl[i].rst;
      ins_valid  = tbl[i].iv;
      ins        = tbl[i].w;
      {ld_done, calc_done, sv_done} = tbl[i].dn;
      {ld_done_bank, calc_done_bank, sv_done_bank} = tbl[i].db;
      step();
      vv = {conf_valid, ld_valid, calc_valid, sv_valid};
      chk($sformatf("vec%0d valids", i), 64'(vv), 64'(tbl[i].ev));
      chk($sformatf("vec%0d working", i), 64'(working), 64'(tbl[i].ew));
      chk($sformatf("vec%0d err_illegal", i), 64'(err_illegal), 64'(tbl[i].eil));
      chk($sformatf("vec%0d err_seq", i), 64'(err_seq), 64'(tbl[i].esq));
      chk($sformatf("vec%0d ins_ready", i), 64'(ins_ready), 64'd1);
    end
    idle_in();
    core_rst_n = 1'b1;

    // different banks overlap; calc_done on bank 0 arrives late
    do_reset();
    push(L0); push(C0); push(L1); push(C1);
    ld_done = 1'b1; ld_done_bank = 1'b0; step(); ld_done = 1'b0;
    chk("t3 calc b0 valid", 64'(calc_valid), 64'd1);
    chk("t3 calc b0 word", issue_ins, C0);
    step();
    chk("t3 load b1 valid", 64'(ld_valid), 64'd1);
    chk("t3 load b1 word", issue_ins, L1);
    step();
    chk("t3 calc b1 blocked", 64'(calc_valid), 64'd0);
    ld_done = 1'b1; ld_done_bank = 1'b1; step(); ld_done = 1'b0;
    chk("t3 calc b1 valid", 64'(calc_valid), 64'd1);
    chk("t3 calc b1 word", issue_ins, C1);
    for (int k = 0; k < 20; k++) step();
    chk("t3 working while calcing", 64'(working), 64'd1);
    calc_done = 1'b1; calc_done_bank = 1'b1; step();
    calc_done_bank = 1'b0; step(); calc_done = 1'b0;
    step();
    chk("t3 no err_seq", 64'(err_seq), 64'd0);

    // back-pressure: 9 loads with ld_ready low
    do_reset();
    ld_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("t4 ready before push%0d", i), 64'(ins_ready), 64'd1);
      push(mk(4'd2, 4'(i % 2), 56'(i) + 56'h400));
    end
    chk("t4 full", 64'(ins_ready), 64'd0);
    step();
    chk("t4 still full", 64'(ins_ready), 64'd0);
    chk("t4 held word", issue_ins, mk(4'd2, 4'd0, 56'h400));
    chk("t4 held valid", 64'(ld_valid), 64'd1);
    ld_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 9; c++) begin
      if (ld_valid) begin
        chk($sformatf("t4 order%0d", got), issue_ins,
            mk(4'd2, 4'(got % 2), 56'(got) + 56'h400));
        got++;
      end
      step();
    end
    chk("t4 drained count", 64'(got), 64'd9);

    // reset while calc_valid is held and three words are queued
    do_reset();
    calc_ready = 1'b0;
    push(L0); push(C0); step();
    ld_done = 1'b1; ld_done_bank = 1'b0; step(); ld_done = 1'b0;
    push(L1); push(L1); push(L0);
    chk("t6 calc held", 64'(calc_valid), 64'd1);
    chk("t6 working before", 64'(working), 64'd1);
    core_rst_n = 1'b0;
    ld_done = 1'b1; calc_done = 1'b1;
    step();
    core_rst_n = 1'b1;
    ld_done = 1'b0; calc_done = 1'b0;
    vv = {conf_valid, ld_valid, calc_valid, sv_valid};
    chk("t6 valids cleared", 64'(vv), 64'd0);
    chk("t6 working cleared", 64'(working), 64'd0);
    chk("t6 ins_ready", 64'(ins_ready), 64'd1);
    chk("t6 issue_ins cleared", issue_ins, 64'd0);
    step();
    vv = {conf_valid, ld_valid, calc_valid, sv_valid};
    chk("t6 fifo flushed", 64'(vv), 64'd0);
    chk("t6 banks idle", 64'(working), 64'd0);
    chk("t6 no err_seq", 64'(err_seq), 64'd0);
    calc_ready = 1'b1;
    push(CF); step();
    chk("t6 conf after reset", 64'(conf_valid), 64'd1);
    chk("t6 conf word", issue_ins, CF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
